i2s_dac_tx: RTL and testbench
=============================

Name: i2s_dac_tx

Overview:
- Playback-side serializer at the far end of the DAC FIFO: pops processed {left,right} 32-bit words written by the effects processor and transmits them to the audio codec as standard I2S.
- Generates the codec bit clock (bclk) and word select (lrclk) from the system clock, one stereo frame per FIFO word.
- On FIFO underrun it transmits silence and counts the event.

Parameters:
- BCLK_HALF, 4, clk cycles per bclk half-period (bclk = clk/(2*BCLK_HALF)); 24.576 MHz clk -> 3.072 MHz bclk -> 48 kHz frames; legal values >= 2.
- UCNT_W, 16, width of the underrun counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  transmit enable; low = idle and hold framing in reset state.
- empty_dac  in  1  DAC FIFO empty flag.
- dac_fifo_out  in  32  show-ahead FIFO head: [31:16] left, [15:0] right, signed; valid whenever empty_dac = 0.
- rd_dac  out  1  one-cycle pop strobe to the DAC FIFO.
- bclk  out  1  I2S bit clock to the codec.
- lrclk  out  1  I2S word select: 0 = left, 1 = right.
- sdata  out  1  I2S serial data, MSB first.
- underrun  out  1  one-cycle pulse when a frame starts with the FIFO empty.
- underrun_cnt  out  UCNT_W  saturating count of underrun frames.

Behaviour:
- Reset (rst_n low, asynchronous): div_cnt = 0, bclk = 0, lrclk = 0, sdata = 0, bit_cnt = 63, frame register F = 0, underrun = 0, underrun_cnt = 0. rd_dac is 0 throughout reset.
- Divider: while en = 1, div_cnt counts 0..BCLK_HALF-1. At div_cnt = BCLK_HALF-1, bclk toggles and div_cnt wraps to 0.
- Fall tick: the clk cycle in which bclk toggles 1 -> 0. All of bit_cnt, lrclk, sdata and F update only on a fall tick. bclk, lrclk and sdata are registered outputs.
- Frame: bit_cnt increments modulo 64 on every fall tick. After the tick, lrclk = (bit_cnt >= 32).
- Frame load (fall tick with bit_cnt 63 -> 0):
  - If empty_dac = 0: F <= {L, 16'h0000, R, 16'h0000}; rd_dac = 1 in that same cycle (combinational: fall tick and bit_cnt = 63 and en and !empty_dac).
  - If empty_dac = 1: F <= 0; rd_dac = 0; underrun = 1 for that cycle; underrun_cnt increments, saturating at all-ones.
- Serial data (one-bclk I2S delay):
  - After a fall tick to bit_cnt = k with 1 <= k <= 63: sdata = F[64-k].
  - At k = 0: sdata = 0 (trailing padding of the previous frame).
  - Left MSB therefore appears one bclk after lrclk falls; right MSB appears one bclk after lrclk rises.
- Latency: after en rises from the idle state, the first fall tick and first rd_dac occur 2*BCLK_HALF clk cycles later. Frame period = 128*BCLK_HALF clk cycles; at most one pop per frame.
- en low (including mid-frame): in the next cycle, return to the reset values for all state except underrun_cnt, which is retained. No rd_dac while en = 0. When en returns high, transmission restarts with a fresh frame load.
- Codec timing: data changes only on bclk falling edges, so the codec samples on rising edges.
- FIFO handling:
  - empty_dac toggling mid-frame has no effect; it is sampled only at the frame-load tick.
  - Pop and underrun can never occur in the same cycle.
  - full_dac is not this block's concern.

Test Plan:
- Single word: BCLK_HALF = 4, FIFO holds 32'h8001_7FFE, en rises -> rd_dac pulses once at cycle 8. Sampling sdata on bclk rising edges gives left slot bits 1000_0000_0000_0001 followed by 16 zeros, and right slot 0111_1111_1111_1110 followed by 16 zeros. lrclk is low for 32 bclk and high for 32 bclk, and each MSB lags its lrclk edge by one bclk.
- Continuous stream: FIFO preloaded with 4 words -> exactly one rd_dac per 512 clk cycles and 4 frames reproduced bit-exact. The 5th frame is all zeros with underrun pulsing once and underrun_cnt = 1.
- Underrun saturation: UCNT_W = 2, FIFO empty for 5 frames -> underrun_cnt sequence 1, 2, 3, 3, 3; rd_dac never asserts.
- en dropped mid left slot (bit_cnt = 20) -> next cycle bclk = lrclk = sdata = 0 and no rd_dac. On re-enable, a new word is popped after 8 cycles and transmitted from its MSB; underrun_cnt is unchanged.
- Async reset mid-frame: rst_n pulsed low for 3 clk cycles between clk edges -> all outputs go to their reset values immediately and underrun_cnt clears. Framing restarts cleanly 8 cycles after release.
- Divider check: BCLK_HALF = 2 -> bclk period 4 clk cycles, frame period 256 clk cycles, first rd_dac at cycle 4.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: pops stereo words from the DAC FIFO and serializes them as I2S.
// One {left,right} word per 64-bit frame; 16-bit samples left-justified in
// 32-bit slots with the standard one-bclk data delay after each lrclk edge.
module i2s_dac_tx #(
  parameter int unsigned BCLK_HALF = 4,
  parameter int unsigned UCNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              empty_dac,
  input  logic [31:0]       dac_fifo_out,
  output logic              rd_dac,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt
);

  localparam int unsigned DIV_W   = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int unsigned FRAME_W = 64;
  localparam int unsigned BIT_W   = 6;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BIT_W-1:0]   bit_nxt;
  logic [BIT_W-1:0]   bit_idx;
  logic [FRAME_W-1:0] frame;
  logic               toggle;
  logic               fall_tick;
  logic               frame_tick;

  // Tick decode: bclk toggles at the end of each half period; a falling
  // toggle advances the frame, and the falling toggle out of bit 63 loads it.
  assign toggle     = en && (div_cnt == DIV_LAST);
  assign fall_tick  = toggle && bclk;
  assign frame_tick = fall_tick && (bit_cnt == BIT_LAST);
  assign rd_dac     = frame_tick && !empty_dac;

  // Bit position after this tick, and the frame bit it exposes (one-bclk delay).
  assign bit_nxt = bit_cnt + BIT_W'(1);
  assign bit_idx = BIT_W'(7'd64 - {1'b0, bit_nxt});

  // Bit clock divider; en low parks the divider and bclk low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (toggle) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Framing and serial data; everything moves only on bclk falling edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= BIT_LAST;
      lrclk   <= 1'b0;
      sdata   <= 1'b0;
      frame   <= '0;
    end else if (!en) begin
      bit_cnt <= BIT_LAST;
      lrclk   <= 1'b0;
      sdata   <= 1'b0;
      frame   <= '0;
    end else if (fall_tick) begin
      bit_cnt <= bit_nxt;
      lrclk   <= bit_nxt[BIT_W-1];
      sdata   <= (bit_nxt == '0) ? 1'b0 : frame[bit_idx];
      if (frame_tick) begin
        frame <= empty_dac ? '0
                           : {dac_fifo_out[31:16], 16'h0000, dac_fifo_out[15:0], 16'h0000};
      end
    end
  end

  // Underrun pulse and saturating counter; the counter survives en low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun <= frame_tick && empty_dac;
      if (frame_tick && empty_dac && (underrun_cnt != '1)) begin
        underrun_cnt <= underrun_cnt + UCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: FIFO models, a bclk-rising-edge capture log and
// frame-by-frame comparison against hand-computed words.
module tb_i2s_dac_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  // Instance A: BCLK_HALF = 4, UCNT_W = 16
  logic        en, empty_dac, rd_dac, bclk, lrclk, sdata, underrun;
  logic [31:0] dac_fifo_out;
  logic [15:0] underrun_cnt;

  // Instance B: BCLK_HALF = 2, UCNT_W = 2
  logic        en_b, empty_b, rd_b, bclk_b, lrclk_b, sdata_b, underrun_b;
  logic [31:0] fifo_out_b;
  logic [1:0]  ucnt_b;

  i2s_dac_tx #(.BCLK_HALF(4), .UCNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .empty_dac(empty_dac),
    .dac_fifo_out(dac_fifo_out), .rd_dac(rd_dac), .bclk(bclk), .lrclk(lrclk),
    .sdata(sdata), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  i2s_dac_tx #(.BCLK_HALF(2), .UCNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .empty_dac(empty_b),
    .dac_fifo_out(fifo_out_b), .rd_dac(rd_b), .bclk(bclk_b), .lrclk(lrclk_b),
    .sdata(sdata_b), .underrun(underrun_b), .underrun_cnt(ucnt_b)
  );

  always #5 clk = ~clk;

  // Cycle counter: number of clk posedges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models (show-ahead), popped on rd strobes.
  logic [31:0] mem_a [0:15];
  logic [31:0] mem_b [0:15];
  int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;
  always @(posedge clk) begin
    if (rd_dac) rp_a <= rp_a + 1;
    if (rd_b)   rp_b <= rp_b + 1;
  end
  assign empty_dac    = (wp_a == rp_a);
  assign dac_fifo_out = mem_a[rp_a[3:0]];
  assign empty_b      = (wp_b == rp_b);
  assign fifo_out_b   = mem_b[rp_b[3:0]];

  // Capture log for instance A: one entry per bclk rising edge.
  logic        sd_log [0:2047];
  logic        lr_log [0:2047];
  logic [15:0] uc_log [0:2047];
  int          pop_t  [0:63];
  int          ur_t   [0:63];
  int          pop_b  [0:63];
  int          rc = 0, np = 0, nu = 0, npb = 0;
  logic        bclk_q = 1'b0;

  always @(negedge clk) begin
    bclk_q <= bclk;
    if (bclk && !bclk_q && rc < 2048) begin
      sd_log[rc] <= sdata;
      lr_log[rc] <= lrclk;
      uc_log[rc] <= underrun_cnt;
      rc         <= rc + 1;
    end
    if (rd_dac && np < 64) begin
      pop_t[np] <= cyc + 1;
      np        <= np + 1;
    end
    if (underrun && nu < 64) begin
      ur_t[nu] <= cyc;
      nu       <= nu + 1;
    end
    if (rd_b && npb < 64) begin
      pop_b[npb] <= cyc + 1;
      npb        <= npb + 1;
    end
  end

  typedef struct {
    logic [31:0] word;
    bit          push;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    logic [15:0] exp_ucnt;
  } vec_t;

  vec_t vt [0:4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_rc(input int target, input string nm);
    int t = 0;
    while (rc < target && t < 6000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, " capture timeout"}, 64'(rc >= target), 64'd1);
  endtask

  task automatic push_a(input logic [31:0] w);
    mem_a[wp_a[3:0]] = w;
    wp_a = wp_a + 1;
  endtask

  task automatic push_b(input logic [31:0] w);
    mem_b[wp_b[3:0]] = w;
    wp_b = wp_b + 1;
  endtask

  // Compare one captured frame; idx is the log entry of the bit_cnt=1 rising edge.
  task automatic check_frame(input string nm, input int idx,
                             input logic [15:0] el, input logic [15:0] er,
                             input logic [15:0] eu);
    logic [63:0] bits;
    logic [63:0] lrv;
    for (int j = 0; j < 64; j++) begin
      bits[63-j] = sd_log[idx+j];
      lrv[63-j]  = lr_log[idx+j];
    end
    chk({nm, " left"},  64'(bits[63:48]), 64'(el));
    chk({nm, " lpad"},  64'(bits[47:32]), 64'd0);
    chk({nm, " right"}, 64'(bits[31:16]), 64'(er));
    chk({nm, " rpad"},  64'(bits[15:0]),  64'd0);
    chk({nm, " lrclk"}, lrv, 64'h0000_0001_FFFF_FFFE);
    chk({nm, " ucnt"},  64'(uc_log[idx]), 64'(eu));
  endtask

  int c0, c1, base, np0, nu0, np1, nur;
  logic [7:0] exp_bclk;

  initial begin
    vt[0] = '{32'h8001_7FFE, 1'b1, 16'h8001, 16'h7FFE, 16'd0};
    vt[1] = '{32'h1234_ABCD, 1'b1, 16'h1234, 16'hABCD, 16'd0};
    vt[2] = '{32'hFFFF_0001, 1'b1, 16'hFFFF, 16'h0001, 16'd0};
    vt[3] = '{32'h5A5A_C3C3, 1'b1, 16'h5A5A, 16'hC3C3, 16'd0};
    vt[4] = '{32'hDEAD_BEEF, 1'b0, 16'h0000, 16'h0000, 16'd1};

    rst_n = 1'b0;
    en    = 1'b0;
    en_b  = 1'b0;
    tick(3);
    chk("reset bclk",     64'(bclk),         64'd0);
    chk("reset lrclk",    64'(lrclk),        64'd0);
    chk("reset sdata",    64'(sdata),        64'd0);
    chk("reset rd_dac",   64'(rd_dac),       64'd0);
    chk("reset underrun", 64'(underrun),     64'd0);
    chk("reset ucnt",     64'(underrun_cnt), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Stream of four words then one underrun frame.
    for (int i = 0; i < 5; i++) if (vt[i].push) push_a(vt[i].word);
    np0  = np;
    nu0  = nu;
    base = rc;
    c0   = cyc;
    en   = 1'b1;
    wait_rc(base + 2 + 64*5, "stream");
    en = 1'b0;
    chk("stream k0 sdata", 64'(sd_log[base+1]), 64'd0);
    for (int f = 0; f < 5; f++)
      check_frame($sformatf("stream f%0d", f), base + 2 + 64*f,
                  vt[f].exp_l, vt[f].exp_r, vt[f].exp_ucnt);
    chk("stream pops", 64'(np - np0), 64'd4);
    chk("stream first pop", 64'(pop_t[np0]), 64'(c0 + 8));
    for (int i = 1; i < 4; i++)
      chk($sformatf("stream pop gap %0d", i), 64'(pop_t[np0+i] - pop_t[np0+i-1]), 64'd512);
    nur = 0;
    for (int i = nu0; i < nu; i++) if (ur_t[i] < c0 + 8 + 2560) nur++;
    chk("stream underrun pulses", 64'(nur), 64'd1);
    chk("stream underrun time", 64'(ur_t[nu0]), 64'(c0 + 8 + 2048));

    // en dropped mid left slot, then re-enabled.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    c0 = cyc;
    en = 1'b1;
    tick(20);
    push_a(32'h1357_2468);
    wait_cyc(c0 + 520);
    chk("drop pop W1", 64'(pop_t[np-1]), 64'(c0 + 520));
    wait_cyc(c0 + 684);
    chk("drop pre bclk", 64'(bclk), 64'd1);
    en = 1'b0;
    push_a(32'hC001_0FF0);
    tick(1);
    chk("drop bclk",   64'(bclk),         64'd0);
    chk("drop lrclk",  64'(lrclk),        64'd0);
    chk("drop sdata",  64'(sdata),        64'd0);
    chk("drop ucnt",   64'(underrun_cnt), 64'd1);
    np1 = np;
    tick(30);
    chk("drop no pop", 64'(np - np1), 64'd0);
    base = rc;
    c1   = cyc;
    en   = 1'b1;
    wait_rc(base + 2 + 64, "reenable");
    chk("reenable pops", 64'(np - np1), 64'd1);
    chk("reenable pop time", 64'(pop_t[np1]), 64'(c1 + 8));
    check_frame("reenable", base + 2, 16'hC001, 16'h0FF0, 16'd1);

    // Asynchronous reset between clock edges while running.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset bclk",     64'(bclk),         64'd0);
    chk("areset lrclk",    64'(lrclk),        64'd0);
    chk("areset sdata",    64'(sdata),        64'd0);
    chk("areset rd_dac",   64'(rd_dac),       64'd0);
    chk("areset underrun", 64'(underrun),     64'd0);
    chk("areset ucnt",     64'(underrun_cnt), 64'd0);
    push_a(32'h7FFF_8000);
    repeat (3) @(posedge clk);
    #2;
    np1   = np;
    base  = rc;
    c1    = cyc;
    rst_n = 1'b1;
    wait_rc(base + 2 + 64, "areset");
    chk("areset pop time", 64'(pop_t[np1]), 64'(c1 + 8));
    check_frame("areset", base + 2, 16'h7FFF, 16'h8000, 16'd0);
    en = 1'b0;
    tick(4);

    // Instance B: fast divider, two words then saturating underruns.
    push_b(32'hAAAA_5555);
    push_b(32'h0F0F_F0F0);
    exp_bclk = 8'b0110_0110;
    c0   = cyc;
    en_b = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick(1);
      chk($sformatf("div bclk n%0d", n), 64'(bclk_b), 64'(exp_bclk[8-n]));
    end
    for (int m = 0; m < 7; m++) begin
      wait_cyc(c0 + 4 + 256*m);
      chk($sformatf("sat ucnt f%0d", m), 64'(ucnt_b),
          64'((m < 2) ? 0 : ((m - 1 > 3) ? 3 : m - 1)));
      chk($sformatf("sat underrun f%0d", m), 64'(underrun_b), 64'((m < 2) ? 0 : 1));
    end
    en_b = 1'b0;
    tick(2);
    chk("div pops", 64'(npb), 64'd2);
    chk("div first pop", 64'(pop_b[0]), 64'(c0 + 4));
    chk("div frame period", 64'(pop_b[1] - pop_b[0]), 64'd256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
